// File: rtl/stim_timestep_gen.sv
// ---------------------------------------------------------------------------
// stim_timestep_gen
//
// Stimulus and timestep scheduler for a neuron tile. Once launched with `go`,
// it waits a fixed lead time. It then emits a one-cycle `start` pulse every
// `interval` cycles, for `num_steps` timesteps. With num_steps = 0 it
// free-runs until `stop`. Each `start` carries a per-axon spike vector. Each
// channel i fires once every `period[i]` steps, first on step period-1.
//
// Parameters:
//   NUM_AXONS          number of spike channels
//   AXON_CNT_BIT_WIDTH width of cfg_addr (>= clog2(NUM_AXONS))
//   PERIOD_WIDTH       width of each channel period register
//   INTERVAL_WIDTH     width of the interval input
//   STEP_WIDTH         width of num_steps / step_idx
//   LEAD_CYCLES        cycles from go acceptance to the internal first pulse
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   go                 launch a run (accepted in IDLE or DONE)
//   stop               abort a run, return to IDLE (beats go)
//   interval           start-to-start spacing, values below 2 act as 2
//   num_steps          timesteps per run, 0 = free-run
//   cfg_we/addr/data   period register write port, period 0 disables a channel
//   start              one-cycle timestep pulse
//   spike              spike vector, nonzero only together with start
//   step_idx           index of the current / last timestep
//   busy               a run is in progress
//   done               one-cycle pulse after the last step of a finite run
//
// Optional feature macro: STIM_LFSR_EN
//   When defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1)
//   advances once per pulse. A channel whose period is all-ones then fires
//   randomly from LFSR bit (i mod 16) instead of counting.
//
// All outputs are registered from the FSM state of the previous cycle. The
// visible start therefore trails the internal PULSE state by one cycle. This
// puts the first start LEAD_CYCLES+1 cycles after the go edge. `stop` clears
// the outputs directly, so busy drops on the cycle right after stop.
// ---------------------------------------------------------------------------
module stim_timestep_gen #(
    parameter int NUM_AXONS          = 2,
    parameter int AXON_CNT_BIT_WIDTH = 1,
    parameter int PERIOD_WIDTH       = 8,
    parameter int INTERVAL_WIDTH     = 16,
    parameter int STEP_WIDTH         = 16,
    parameter int LEAD_CYCLES        = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          go,
    input  logic                          stop,
    input  logic [INTERVAL_WIDTH-1:0]     interval,
    input  logic [STEP_WIDTH-1:0]         num_steps,
    input  logic                          cfg_we,
    input  logic [AXON_CNT_BIT_WIDTH-1:0] cfg_addr,
    input  logic [PERIOD_WIDTH-1:0]       cfg_data,
    output logic                          start,
    output logic [NUM_AXONS-1:0]          spike,
    output logic [STEP_WIDTH-1:0]         step_idx,
    output logic                          busy,
    output logic                          done
);

    // LEAD_CYCLES = 0 behaves like 1, so the load value never underflows.
    localparam int LEAD_LOAD = (LEAD_CYCLES > 0) ? LEAD_CYCLES - 1 : 0;
    localparam int LEAD_W    = (LEAD_LOAD > 0) ? $clog2(LEAD_LOAD + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_PULSE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                    state;
    logic [LEAD_W-1:0]         lead_cnt;
    logic [INTERVAL_WIDTH-1:0] interval_q;
    logic [INTERVAL_WIDTH-1:0] wait_cnt;
    logic [STEP_WIDTH-1:0]     steps_q;
    logic [STEP_WIDTH-1:0]     step;
    logic                      done_first;

    logic [PERIOD_WIDTH-1:0]   period_q [NUM_AXONS];
    logic [PERIOD_WIDTH-1:0]   cnt_q    [NUM_AXONS];

    logic                      go_accept;
    logic [NUM_AXONS-1:0]      wr_hit;
    logic [NUM_AXONS-1:0]      rand_ch;
    logic [NUM_AXONS-1:0]      spike_next;

`ifdef STIM_LFSR_EN
    logic [15:0]               lfsr;
    logic                      lfsr_fb;
`endif

    // Launch decode, write-address decode and the spike vector for the
    // current PULSE.
    always_comb begin
        go_accept  = go && !stop && (state == S_IDLE || state == S_DONE);
        wr_hit     = '0;
        rand_ch    = '0;
        spike_next = '0;
`ifdef STIM_LFSR_EN
        lfsr_fb    = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
`endif
        for (int i = 0; i < NUM_AXONS; i++) begin
            wr_hit[i]     = cfg_we && (cfg_addr == AXON_CNT_BIT_WIDTH'(i));
            spike_next[i] = (period_q[i] != '0) && (cnt_q[i] == PERIOD_WIDTH'(1));
`ifdef STIM_LFSR_EN
            if (period_q[i] == '1) begin
                rand_ch[i]    = 1'b1;
                spike_next[i] = lfsr[4'(i % 16)];
            end
`endif
        end
    end

    // Period registers. Addresses with no matching channel never hit, so
    // out-of-range writes are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_AXONS; i++) begin
                period_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_AXONS; i++) begin
                if (wr_hit[i]) begin
                    period_q[i] <= cfg_data;
                end
            end
        end
    end

    // Per-channel down-counters. A write only reaches a counter that is
    // currently disabled, or one being launched in the same cycle as go.
    // Running counts pick up new periods at their next reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_AXONS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_AXONS; i++) begin
                if (go_accept) begin
                    cnt_q[i] <= wr_hit[i] ? cfg_data : period_q[i];
                end else if (wr_hit[i] && period_q[i] == '0) begin
                    cnt_q[i] <= cfg_data;
                end else if (state == S_PULSE && period_q[i] != '0 && !rand_ch[i]) begin
                    if (cnt_q[i] > PERIOD_WIDTH'(1)) begin
                        cnt_q[i] <= cnt_q[i] - 1'b1;
                    end else begin
                        cnt_q[i] <= period_q[i];
                    end
                end
            end
        end
    end

`ifdef STIM_LFSR_EN
    // Random source for all-ones channels. It shifts right and feeds back
    // into bit 15, and it advances once per timestep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else if (state == S_PULSE) begin
            lfsr <= {lfsr_fb, lfsr[15:1]};
        end
    end
`endif

    // Main FSM plus the registered output stage. Outputs reflect the state
    // held during this cycle, and stop clears them at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            lead_cnt   <= '0;
            interval_q <= '0;
            wait_cnt   <= '0;
            steps_q    <= '0;
            step       <= '0;
            done_first <= 1'b0;
            start      <= 1'b0;
            spike      <= '0;
            step_idx   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            start    <= !stop && (state == S_PULSE);
            spike    <= (!stop && state == S_PULSE) ? spike_next : '0;
            busy     <= !stop && (state == S_LEAD || state == S_PULSE || state == S_WAIT);
            done     <= !stop && (state == S_DONE) && done_first;
            step_idx <= step;

            if (stop) begin
                state      <= S_IDLE;
                done_first <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        done_first <= 1'b0;
                        if (go) begin
                            interval_q <= (interval < INTERVAL_WIDTH'(2)) ? INTERVAL_WIDTH'(2) : interval;
                            steps_q    <= num_steps;
                            lead_cnt   <= LEAD_W'(LEAD_LOAD);
                            step       <= '0;
                            state      <= S_LEAD;
                        end
                    end
                    S_LEAD: begin
                        if (lead_cnt == '0) begin
                            state <= S_PULSE;
                        end else begin
                            lead_cnt <= lead_cnt - 1'b1;
                        end
                    end
                    S_PULSE: begin
                        if (steps_q != '0 && step == steps_q - 1'b1) begin
                            state      <= S_DONE;
                            done_first <= 1'b1;
                        end else begin
                            // WAIT spans interval-1 cycles, so the pulse
                            // spacing comes out to exactly interval.
                            wait_cnt <= interval_q - INTERVAL_WIDTH'(2);
                            state    <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (wait_cnt == '0) begin
                            if (step != '1) begin
                                step <= step + 1'b1;
                            end
                            state <= S_PULSE;
                        end else begin
                            wait_cnt <= wait_cnt - 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
